kf_seq_ctrl: RTL
================

KF_SEQ_CTRL -- requirements
Module: kf_seq_ctrl

Interface
REQ-001 Parameter ITER_W, default 16, width of iteration limit and counter.
REQ-002 Parameter TMO_W, default 20, width of per-stage watchdog limit and counter.
REQ-003 Parameter N_SCU, default 2, number of covariance-update done flags.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high. Ports: clk in 1, clock; rst in 1, asynchronous active-high reset.
REQ-005 Control inputs:
- start in 1: run request, rising-edge sensitive.
- abort in 1: abandon the current run.
- max_iter in ITER_W: iteration limit; 0 = unlimited.
- tmo_limit in TMO_W: per-stage cycle limit; 0 = watchdog disabled.
REQ-006 Stage status inputs, each 1 bit unless stated: init_valid, sp_done, ckg_done, mdi_valid, scu_done (N_SCU bits, one per update unit), sco_valid, end_valid.
REQ-007 Stage enable outputs, 1 bit each: en_init, en_sp, en_ckg, en_mdi, en_scu, en_sco.
REQ-008 Status outputs:
- busy out 1.
- finish out 1: one-cycle completion pulse.
- err out 1: sticky error flag.
- err_code out 3: stage that timed out.
- iter_cnt out ITER_W: completed iterations.

Function
REQ-009 The block SHALL have the states IDLE, INIT, SP, CKG, MDI, SCU, SCO, DONE and ERR.
REQ-010 IDLE->INIT SHALL occur the cycle after start is first sampled high following a low sample; max_iter and tmo_limit are captured at this transition and held for the run.
REQ-011 A start level held high, or a start edge in any state other than IDLE or ERR, SHALL be ignored.
REQ-012 Stage transitions advance on one sampled-high cycle of the named input: INIT->SP on init_valid, SP->CKG on sp_done, CKG->MDI on ckg_done, MDI->SCU on mdi_valid.
REQ-013 In SCU, each scu_done bit SHALL be latched sticky; SCU->SCO occurs when every bit is latched or high in the current cycle; latches clear on leaving SCU.
REQ-014 In SCO with sco_valid, iter_cnt SHALL increment (saturating at all-ones); the next state is DONE if end_valid is high or (max_iter != 0 and the incremented value == max_iter), else SP.
REQ-015 In SCO with end_valid and no sco_valid, the next state SHALL be DONE with iter_cnt unchanged.
REQ-016 DONE SHALL last exactly one cycle with finish=1, then go to IDLE; finish is never asserted in any other state.
REQ-017 Each enable SHALL be high exactly while in its like-named state; all enables are low in IDLE, DONE and ERR.
REQ-018 busy SHALL be 1 in INIT through SCO and 0 elsewhere.
REQ-019 The watchdog SHALL clear on every state entry and count cycles spent in INIT..SCO.
REQ-020 If tmo_limit != 0 and the counter reaches tmo_limit without the awaited input, the next state SHALL be ERR, with err_code = 1..6 for INIT..SCO.
REQ-021 An awaited input arriving on the timeout cycle SHALL take priority over the timeout.
REQ-022 ERR SHALL hold err=1, err_code and iter_cnt; a start rising edge clears err and err_code and enters INIT; abort clears them and enters IDLE.
REQ-023 abort in any state except IDLE SHALL force IDLE on the next cycle, with priority over all other inputs and no finish pulse.
REQ-024 iter_cnt SHALL clear on entry to INIT and hold its value in IDLE after a run.

Reset
REQ-025 On rst the block SHALL enter IDLE with every output 0, the start edge history 0 and all latches and counters 0, independent of clk.
REQ-026 An rst asserted mid-run SHALL abandon the run without a finish pulse.

Structure
REQ-027 Package kf_ctrl_pkg SHALL hold the state enum (4-bit encoding) and the err_code constants (0 = none, 1..6 = INIT..SCO).
REQ-028 The watchdog SHALL be the sub-module kf_stage_watchdog (inputs clear, enable, limit; output expired), parametrised by TMO_W.

Verification
REQ-029 max_iter=3, tmo_limit=0, all done inputs pulsed 2 cycles after each enable -> three SP..SCO loops, finish pulses once, iter_cnt=3, then IDLE.
REQ-030 N_SCU=2, scu_done[0] pulsed at cycle 2 and scu_done[1] at cycle 5 of SCU -> SCU->SCO the cycle after cycle 5.
REQ-031 tmo_limit=10, ckg_done never asserted -> ERR 10 cycles after CKG entry, err=1, err_code=3; ckg_done exactly on the 10th cycle -> MDI instead.
REQ-032 max_iter=0, end_valid together with sco_valid on the 4th SCO -> DONE, iter_cnt=4.
REQ-033 abort asserted in SCU -> IDLE next cycle, finish=0, all enables 0; start held high through the run -> no restart.
REQ-034 rst asserted asynchronously in MDI -> all outputs 0 immediately; a new start edge after release -> INIT one cycle later.

Source files
------------

// File: rtl/kf_ctrl_pkg.sv
// Shared definitions for the Kalman-filter sequencing controller:
// state encoding, error codes and the stage-to-error-code mapping.
package kf_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_INIT = 4'd1,
    ST_SP   = 4'd2,
    ST_CKG  = 4'd3,
    ST_MDI  = 4'd4,
    ST_SCU  = 4'd5,
    ST_SCO  = 4'd6,
    ST_DONE = 4'd7,
    ST_ERR  = 4'd8
  } kf_state_t;

  localparam logic [2:0] ERRC_NONE = 3'd0;
  localparam logic [2:0] ERRC_INIT = 3'd1;
  localparam logic [2:0] ERRC_SP   = 3'd2;
  localparam logic [2:0] ERRC_CKG  = 3'd3;
  localparam logic [2:0] ERRC_MDI  = 3'd4;
  localparam logic [2:0] ERRC_SCU  = 3'd5;
  localparam logic [2:0] ERRC_SCO  = 3'd6;

  function automatic logic [2:0] stage_err_code(input kf_state_t s);
    case (s)
      ST_INIT: stage_err_code = ERRC_INIT;
      ST_SP:   stage_err_code = ERRC_SP;
      ST_CKG:  stage_err_code = ERRC_CKG;
      ST_MDI:  stage_err_code = ERRC_MDI;
      ST_SCU:  stage_err_code = ERRC_SCU;
      ST_SCO:  stage_err_code = ERRC_SCO;
      default: stage_err_code = ERRC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/kf_stage_watchdog.sv
// Per-stage cycle watchdog: expired is high during the limit-th cycle
// spent in a stage, so an input arriving that same cycle can still win.
module kf_stage_watchdog #(
  parameter int TMO_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [TMO_W-1:0] limit,
  output logic             expired
);

  localparam logic [TMO_W-1:0] TMO_ONE = TMO_W'(1);

  logic [TMO_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != '1)) begin
      cnt <= cnt + TMO_ONE;
    end
  end

  // cnt holds completed cycles, so cnt == limit-1 marks the limit-th cycle
  assign expired = enable && (limit != '0) && (cnt == (limit - TMO_ONE));

endmodule

// File: rtl/kf_seq_ctrl.sv
// Sequencer for the Kalman-filter stages: walks INIT, then SP..SCO loops,
// with per-stage watchdog, abort, iteration limit and sticky error state.
module kf_seq_ctrl
  import kf_ctrl_pkg::*;
#(
  parameter int ITER_W = 16,
  parameter int TMO_W  = 20,
  parameter int N_SCU  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ITER_W-1:0] max_iter,
  input  logic [TMO_W-1:0]  tmo_limit,
  input  logic              init_valid,
  input  logic              sp_done,
  input  logic              ckg_done,
  input  logic              mdi_valid,
  input  logic [N_SCU-1:0]  scu_done,
  input  logic              sco_valid,
  input  logic              end_valid,
  output logic              en_init,
  output logic              en_sp,
  output logic              en_ckg,
  output logic              en_mdi,
  output logic              en_scu,
  output logic              en_sco,
  output logic              busy,
  output logic              finish,
  output logic              err,
  output logic [2:0]        err_code,
  output logic [ITER_W-1:0] iter_cnt
);

  localparam logic [ITER_W-1:0] ITER_ONE = ITER_W'(1);

  kf_state_t         state, state_nxt;
  logic              start_q;
  logic              start_rise;
  logic [ITER_W-1:0] max_iter_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [ITER_W-1:0] iter_q;
  logic [ITER_W-1:0] iter_inc;
  logic [N_SCU-1:0]  scu_lat;
  logic              scu_all;
  logic [2:0]        err_code_q;
  logic              in_stage;
  logic              wd_exp;

  assign start_rise = start & ~start_q;
  assign iter_inc   = (iter_q == '1) ? iter_q : (iter_q + ITER_ONE);
  assign scu_all    = &(scu_lat | scu_done);
  assign in_stage   = (state == ST_INIT) || (state == ST_SP)  || (state == ST_CKG) ||
                      (state == ST_MDI)  || (state == ST_SCU) || (state == ST_SCO);

  kf_stage_watchdog #(
    .TMO_W (TMO_W)
  ) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_nxt != state),
    .enable  (in_stage),
    .limit   (tmo_q),
    .expired (wd_exp)
  );

  // The awaited input is tested before the watchdog, so it wins on the timeout cycle
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_rise) state_nxt = ST_INIT;
      ST_INIT: if (init_valid) state_nxt = ST_SP;  else if (wd_exp) state_nxt = ST_ERR;
      ST_SP:   if (sp_done)    state_nxt = ST_CKG; else if (wd_exp) state_nxt = ST_ERR;
      ST_CKG:  if (ckg_done)   state_nxt = ST_MDI; else if (wd_exp) state_nxt = ST_ERR;
      ST_MDI:  if (mdi_valid)  state_nxt = ST_SCU; else if (wd_exp) state_nxt = ST_ERR;
      ST_SCU:  if (scu_all)    state_nxt = ST_SCO; else if (wd_exp) state_nxt = ST_ERR;
      ST_SCO: begin
        if (sco_valid) begin
          if (end_valid || ((max_iter_q != '0) && (iter_inc == max_iter_q)))
            state_nxt = ST_DONE;
          else
            state_nxt = ST_SP;
        end else if (end_valid) begin
          state_nxt = ST_DONE;
        end else if (wd_exp) begin
          state_nxt = ST_ERR;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      ST_ERR:  if (start_rise) state_nxt = ST_INIT;
      default: state_nxt = ST_IDLE;
    endcase
    if (abort && (state != ST_IDLE)) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      start_q    <= 1'b0;
      max_iter_q <= '0;
      tmo_q      <= '0;
      iter_q     <= '0;
      scu_lat    <= '0;
      err_code_q <= ERRC_NONE;
    end else begin
      state   <= state_nxt;
      start_q <= start;

      if ((state_nxt == ST_INIT) && (state != ST_INIT)) begin
        max_iter_q <= max_iter;
        tmo_q      <= tmo_limit;
        iter_q     <= '0;
      end else if ((state == ST_SCO) && sco_valid && !abort) begin
        iter_q <= iter_inc;
      end

      if ((state == ST_SCU) && (state_nxt == ST_SCU))
        scu_lat <= scu_lat | scu_done;
      else
        scu_lat <= '0;

      if (state_nxt == ST_ERR) begin
        if (state != ST_ERR) err_code_q <= stage_err_code(state);
      end else begin
        err_code_q <= ERRC_NONE;
      end
    end
  end

  assign en_init  = (state == ST_INIT);
  assign en_sp    = (state == ST_SP);
  assign en_ckg   = (state == ST_CKG);
  assign en_mdi   = (state == ST_MDI);
  assign en_scu   = (state == ST_SCU);
  assign en_sco   = (state == ST_SCO);
  assign busy     = in_stage;
  assign finish   = (state == ST_DONE);
  assign err      = (state == ST_ERR);
  assign err_code = err_code_q;
  assign iter_cnt = iter_q;

endmodule
